// File: rtl/i2c_host_fifo_pkg.sv
// Shared I2C definitions: host sequencer states and transfer limits.
package i2c_pkg;

  localparam int I2C_MAX_LEN = 16;
  localparam int I2C_BYTE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } host_st_t;

endpackage

// File: rtl/i2c_host_fifo_sync_byte_fifo.sv
// Show-ahead byte FIFO. The head byte is held in a register so the output
// is defined out of reset and holds its value across an underflowing pop.
module sync_byte_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                  clk_en,
  input  logic                  rst,
  input  logic                  push,
  input  logic [I2C_BYTE_W-1:0] wdata,
  input  logic                  pop,
  output logic [I2C_BYTE_W-1:0] rdata,
  output logic [AW:0]           level,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic                  udf
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  logic [I2C_BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_level;
  logic [I2C_BYTE_W-1:0] r_head;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop_ok;
  logic                  w_push_ok;
  logic [AW-1:0]         w_rd_nxt;

  assign w_full    = (r_level == LVL_FULL);
  assign w_empty   = (r_level == '0);
  assign w_pop_ok  = pop & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign w_push_ok = push & (~w_full | w_pop_ok);
  assign w_rd_nxt  = r_rd_ptr + AW'(1);

  // Storage array: data only, no reset.
  always_ff @(posedge clk_en) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointers, occupancy and head-of-queue register.
  always_ff @(posedge clk_en or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= w_rd_nxt;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      // Next head comes from memory while more than one entry remains;
      // otherwise a byte landing in an (about to be) empty FIFO bypasses.
      if (w_pop_ok && (r_level > LVL_ONE))
        r_head <= r_mem[w_rd_nxt];
      else if (w_push_ok && ((r_level == '0) || (w_pop_ok && (r_level == LVL_ONE))))
        r_head <= wdata;
    end
  end

  assign rdata = r_head;
  assign level = r_level;
  assign full  = w_full;
  assign empty = w_empty;
  assign ovf   = push & ~w_push_ok;
  assign udf   = pop & ~w_pop_ok;

endmodule

// File: rtl/i2c_host_fifo.sv
// Host-side TX/RX byte buffering and transfer sequencing for the I2C master.
// Master strobes are synchronized and edge-detected here; each edge becomes
// at most one FIFO pointer update.
module i2c_host_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                  clk_en,
  input  logic                  rst,
  input  logic                  tx_wr,
  input  logic [I2C_BYTE_W-1:0] tx_wdata,
  input  logic                  rx_rd,
  output logic [I2C_BYTE_W-1:0] rx_rdata,
  input  logic                  start,
  input  logic [6:0]            cfg_addr,
  input  logic                  cfg_rw,
  input  logic [4:0]            cfg_len,
  output logic                  busy,
  output logic                  done_irq,
  output logic [AW:0]           tx_level,
  output logic [AW:0]           rx_level,
  output logic                  tx_full,
  output logic                  tx_empty,
  output logic                  rx_full,
  output logic                  rx_empty,
  output logic                  err_ovf,
  output logic                  err_udf,
  output logic                  err_cfg,
  input  logic                  err_clr,
  output logic                  i_ready,
  output logic [6:0]            addr,
  output logic                  rw,
  output logic [3:0]            data_cnt,
  output logic [I2C_BYTE_W-1:0] data_in,
  input  logic                  txff_rd,
  input  logic                  rxff_wr,
  input  logic [I2C_BYTE_W-1:0] rx_byte,
  input  logic                  i2c_done
);

  host_st_t    r_state;
  host_st_t    w_state_nxt;

  // Bit 0: txff_rd, bit 1: rxff_wr, bit 2: i2c_done.
  logic [2:0]  r_sync1;
  logic [2:0]  r_sync2;
  logic [2:0]  r_dly;
  logic        w_tx_rise;
  logic        w_tx_fall;
  logic        w_rx_rise;
  logic        w_done_fall;

  logic [6:0]  r_addr;
  logic        r_rw;
  logic [3:0]  r_cnt;
  logic [4:0]  r_len;
  logic [4:0]  r_beats;
  logic        r_err_ovf;
  logic        r_err_udf;
  logic        r_err_cfg;

  logic        w_cfg_bad;
  logic        w_accept;
  logic        w_cfg_rej;
  logic        w_tx_pop;
  logic        w_rx_push;
  logic        w_tx_ovf;
  logic        w_tx_udf;
  logic        w_rx_ovf;
  logic        w_rx_udf;
  logic [31:0] w_len32;
  logic [31:0] w_txl32;
  logic [31:0] w_rxfree32;

  // Two-flop synchronizers plus one delay flop for edge detection.
  always_ff @(posedge clk_en or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_dly   <= '0;
    end else begin
      r_sync1 <= {i2c_done, rxff_wr, txff_rd};
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  assign w_tx_rise   =  r_sync2[0] & ~r_dly[0];
  assign w_tx_fall   = ~r_sync2[0] &  r_dly[0];
  assign w_rx_rise   =  r_sync2[1] & ~r_dly[1];
  assign w_done_fall = ~r_sync2[2] &  r_dly[2];

  assign w_len32    = 32'(cfg_len);
  assign w_txl32    = 32'(tx_level);
  assign w_rxfree32 = 32'(DEPTH) - 32'(rx_level);
  assign w_cfg_bad  = (cfg_len == 5'd0) || (w_len32 > 32'(I2C_MAX_LEN)) ||
                      (!cfg_rw && (w_txl32 < w_len32)) ||
                      ( cfg_rw && (w_rxfree32 < w_len32));

  // Sequencer state register.
  always_ff @(posedge clk_en or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state decode and per-cycle FIFO strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cfg_rej   = 1'b0;
    w_tx_pop    = 1'b0;
    w_rx_push   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_cfg_bad) begin
            w_cfg_rej = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // A NACKed address produces no data strobes, only completion.
        if (w_done_fall)    w_state_nxt = ST_DONE;
        else if (w_tx_rise) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (!r_rw && w_tx_fall && (r_beats < r_len)) w_tx_pop  = 1'b1;
        if ( r_rw && w_rx_rise && (r_beats < r_len)) w_rx_push = 1'b1;
        if (w_done_fall) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Transfer configuration latch and beat counter.
  always_ff @(posedge clk_en or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_beats <= '0;
    end else if (w_accept) begin
      r_addr  <= cfg_addr;
      r_rw    <= cfg_rw;
      r_cnt   <= 4'(cfg_len - 5'd1);
      r_len   <= cfg_len;
      r_beats <= '0;
    end else if (w_tx_pop || w_rx_push) begin
      r_beats <= r_beats + 5'd1;
    end
  end

  // Sticky error flags; a same-cycle event wins over the clear.
  always_ff @(posedge clk_en or negedge rst) begin
    if (!rst) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
      r_err_cfg <= 1'b0;
    end else begin
      r_err_ovf <= (r_err_ovf & ~err_clr) | w_tx_ovf | w_rx_ovf;
      r_err_udf <= (r_err_udf & ~err_clr) | w_tx_udf | w_rx_udf;
      r_err_cfg <= (r_err_cfg & ~err_clr) | w_cfg_rej;
    end
  end

  sync_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .clk_en (clk_en),
    .rst    (rst),
    .push   (tx_wr),
    .wdata  (tx_wdata),
    .pop    (w_tx_pop),
    .rdata  (data_in),
    .level  (tx_level),
    .full   (tx_full),
    .empty  (tx_empty),
    .ovf    (w_tx_ovf),
    .udf    (w_tx_udf)
  );

  sync_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .clk_en (clk_en),
    .rst    (rst),
    .push   (w_rx_push),
    .wdata  (rx_byte),
    .pop    (rx_rd),
    .rdata  (rx_rdata),
    .level  (rx_level),
    .full   (rx_full),
    .empty  (rx_empty),
    .ovf    (w_rx_ovf),
    .udf    (w_rx_udf)
  );

  assign i_ready  = (r_state == ST_REQ);
  assign busy     = (r_state != ST_IDLE);
  assign done_irq = (r_state == ST_DONE);
  assign addr     = r_addr;
  assign rw       = r_rw;
  assign data_cnt = r_cnt;
  assign err_ovf  = r_err_ovf;
  assign err_udf  = r_err_udf;
  assign err_cfg  = r_err_cfg;

endmodule

// File: tb/tb_i2c_host_fifo.sv
// Directed bench for i2c_host_fifo: host pushes/pops and a simple master
// model driving level strobes; expected values are hand-computed.
module tb_i2c_host_fifo;

  logic       clk_en = 1'b0;
  logic       rst;
  logic       tx_wr;
  logic [7:0] tx_wdata;
  logic       rx_rd;
  logic [7:0] rx_rdata;
  logic       start;
  logic [6:0] cfg_addr;
  logic       cfg_rw;
  logic [4:0] cfg_len;
  logic       busy;
  logic       done_irq;
  logic [4:0] tx_level;
  logic [4:0] rx_level;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       err_ovf, err_udf, err_cfg;
  logic       err_clr;
  logic       i_ready;
  logic [6:0] addr;
  logic       rw;
  logic [3:0] data_cnt;
  logic [7:0] data_in;
  logic       txff_rd;
  logic       rxff_wr;
  logic [7:0] rx_byte;
  logic       i2c_done;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  i2c_host_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk_en(clk_en), .rst(rst), .tx_wr(tx_wr), .tx_wdata(tx_wdata),
    .rx_rd(rx_rd), .rx_rdata(rx_rdata), .start(start), .cfg_addr(cfg_addr),
    .cfg_rw(cfg_rw), .cfg_len(cfg_len), .busy(busy), .done_irq(done_irq),
    .tx_level(tx_level), .rx_level(rx_level), .tx_full(tx_full),
    .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_cfg(err_cfg), .err_clr(err_clr),
    .i_ready(i_ready), .addr(addr), .rw(rw), .data_cnt(data_cnt),
    .data_in(data_in), .txff_rd(txff_rd), .rxff_wr(rxff_wr),
    .rx_byte(rx_byte), .i2c_done(i2c_done)
  );

  always #5 clk_en = ~clk_en;

  always @(negedge clk_en) if (done_irq === 1'b1) done_cnt++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk_en);
  endtask

  task automatic do_reset;
    rst = 1'b0; tx_wr = 0; tx_wdata = 0; rx_rd = 0; start = 0; cfg_addr = 0;
    cfg_rw = 0; cfg_len = 0; err_clr = 0; txff_rd = 0; rxff_wr = 0;
    rx_byte = 0; i2c_done = 0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic host_push(input logic [7:0] b);
    tx_wr = 1'b1; tx_wdata = b; tick(1); tx_wr = 1'b0;
  endtask

  task automatic do_start(input logic [6:0] a, input logic r, input logic [4:0] l);
    cfg_addr = a; cfg_rw = r; cfg_len = l; start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_tx(input int w);
    txff_rd = 1'b1; tick(w); txff_rd = 1'b0; tick(5);
  endtask

  task automatic pulse_rx(input logic [7:0] b, input int w);
    rx_byte = b; rxff_wr = 1'b1; tick(w); rxff_wr = 1'b0; tick(5);
  endtask

  task automatic pulse_done;
    i2c_done = 1'b1; tick(4); i2c_done = 1'b0; tick(6);
  endtask

  task automatic test_reset;
    do_reset();
    n_chk++; if (tx_empty !== 1'b1 || rx_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got tx=%b rx=%b want 1 1", tx_empty, rx_empty); end
    n_chk++; if (busy !== 1'b0 || i_ready !== 1'b0 || done_irq !== 1'b0) begin n_fail++; $display("FAIL rst_ctl: got busy=%b i_ready=%b done=%b want 0 0 0", busy, i_ready, done_irq); end
    n_chk++; if (tx_level !== 5'd0 || rx_level !== 5'd0 || tx_full !== 1'b0 || rx_full !== 1'b0) begin n_fail++; $display("FAIL rst_level: got %0d %0d full %b %b want 0 0 0 0", tx_level, rx_level, tx_full, rx_full); end
    n_chk++; if ({err_ovf, err_udf, err_cfg} !== 3'b000) begin n_fail++; $display("FAIL rst_err: got %b want 000", {err_ovf, err_udf, err_cfg}); end
    n_chk++; if (data_in !== 8'h00 || rx_rdata !== 8'h00 || addr !== 7'd0 || rw !== 1'b0 || data_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_data: got data_in=%h rx_rdata=%h addr=%h rw=%b cnt=%0d want zeros", data_in, rx_rdata, addr, rw, data_cnt); end
  endtask

  task automatic test_write3;
    int d0;
    do_reset();
    host_push(8'hA5);
    n_chk++; if (tx_level !== 5'd1 || data_in !== 8'hA5) begin n_fail++; $display("FAIL wr_first_push: got level=%0d data_in=%h want 1 a5", tx_level, data_in); end
    host_push(8'h3C);
    host_push(8'h7E);
    n_chk++; if (tx_level !== 5'd3 || data_in !== 8'hA5) begin n_fail++; $display("FAIL wr_level3: got level=%0d data_in=%h want 3 a5", tx_level, data_in); end
    do_start(7'h50, 1'b0, 5'd3);
    n_chk++; if (i_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL wr_req: got i_ready=%b busy=%b want 1 1", i_ready, busy); end
    n_chk++; if (addr !== 7'h50 || rw !== 1'b0 || data_cnt !== 4'd2) begin n_fail++; $display("FAIL wr_cfg: got addr=%h rw=%b cnt=%0d want 50 0 2", addr, rw, data_cnt); end
    tick(4);
    n_chk++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_hold: got %b want 1", i_ready); end
    txff_rd = 1'b1; tick(6);
    n_chk++; if (i_ready !== 1'b0 || busy !== 1'b1 || data_in !== 8'hA5 || tx_level !== 5'd3) begin n_fail++; $display("FAIL wr_ack_phase: got i_ready=%b busy=%b data_in=%h level=%0d want 0 1 a5 3", i_ready, busy, data_in, tx_level); end
    txff_rd = 1'b0; tick(5);
    n_chk++; if (data_in !== 8'h3C || tx_level !== 5'd2) begin n_fail++; $display("FAIL wr_pop1: got data_in=%h level=%0d want 3c 2", data_in, tx_level); end
    pulse_tx(8);
    n_chk++; if (data_in !== 8'h7E || tx_level !== 5'd1) begin n_fail++; $display("FAIL wr_pop2: got data_in=%h level=%0d want 7e 1", data_in, tx_level); end
    pulse_tx(8);
    n_chk++; if (tx_level !== 5'd0 || tx_empty !== 1'b1 || data_in !== 8'h7E) begin n_fail++; $display("FAIL wr_pop3: got level=%0d empty=%b data_in=%h want 0 1 7e", tx_level, tx_empty, data_in); end
    pulse_tx(8);
    n_chk++; if (tx_level !== 5'd0 || err_udf !== 1'b0) begin n_fail++; $display("FAIL wr_extra_strobe: got level=%0d udf=%b want 0 0", tx_level, err_udf); end
    d0 = done_cnt;
    i2c_done = 1'b1; tick(4); i2c_done = 1'b0;
    tick(2);
    n_chk++; if (done_irq !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wr_done_early: got done=%b busy=%b want 0 1", done_irq, busy); end
    tick(1);
    n_chk++; if (done_irq !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL wr_done_pulse: got done=%b busy=%b want 1 1", done_irq, busy); end
    tick(1);
    n_chk++; if (done_irq !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_done_end: got done=%b busy=%b want 0 0", done_irq, busy); end
    tick(3);
    n_chk++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL wr_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_read2;
    do_reset();
    do_start(7'h21, 1'b1, 5'd2);
    n_chk++; if (i_ready !== 1'b1 || rw !== 1'b1 || data_cnt !== 4'd1) begin n_fail++; $display("FAIL rd_req: got i_ready=%b rw=%b cnt=%0d want 1 1 1", i_ready, rw, data_cnt); end
    pulse_tx(6);
    n_chk++; if (i_ready !== 1'b0 || busy !== 1'b1 || err_udf !== 1'b0) begin n_fail++; $display("FAIL rd_busy: got i_ready=%b busy=%b udf=%b want 0 1 0", i_ready, busy, err_udf); end
    pulse_rx(8'h11, 40);
    n_chk++; if (rx_level !== 5'd1 || rx_rdata !== 8'h11) begin n_fail++; $display("FAIL rd_push1: got level=%0d rdata=%h want 1 11", rx_level, rx_rdata); end
    pulse_rx(8'h22, 40);
    n_chk++; if (rx_level !== 5'd2 || rx_rdata !== 8'h11) begin n_fail++; $display("FAIL rd_push2: got level=%0d rdata=%h want 2 11", rx_level, rx_rdata); end
    pulse_rx(8'h33, 40);
    n_chk++; if (rx_level !== 5'd2) begin n_fail++; $display("FAIL rd_extra_push: got level=%0d want 2", rx_level); end
    pulse_done();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle: got busy=%b want 0", busy); end
    rx_rd = 1'b1; tick(1); rx_rd = 1'b0;
    n_chk++; if (rx_rdata !== 8'h22 || rx_level !== 5'd1) begin n_fail++; $display("FAIL rd_pop1: got rdata=%h level=%0d want 22 1", rx_rdata, rx_level); end
    rx_rd = 1'b1; tick(1); rx_rd = 1'b0;
    n_chk++; if (rx_empty !== 1'b1 || rx_rdata !== 8'h22 || err_udf !== 1'b0) begin n_fail++; $display("FAIL rd_pop2: got empty=%b rdata=%h udf=%b want 1 22 0", rx_empty, rx_rdata, err_udf); end
  endtask

  task automatic test_cfg_errors;
    do_reset();
    do_start(7'h10, 1'b0, 5'd0);
    n_chk++; if (err_cfg !== 1'b1 || i_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL cfg_len0: got err=%b i_ready=%b busy=%b want 1 0 0", err_cfg, i_ready, busy); end
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    n_chk++; if (err_cfg !== 1'b0) begin n_fail++; $display("FAIL cfg_clr: got %b want 0", err_cfg); end
    host_push(8'h01);
    host_push(8'h02);
    do_start(7'h10, 1'b0, 5'd4);
    tick(3);
    n_chk++; if (err_cfg !== 1'b1 || i_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL cfg_short_tx: got err=%b i_ready=%b busy=%b want 1 0 0", err_cfg, i_ready, busy); end
    do_start(7'h10, 1'b0, 5'd17);
    n_chk++; if (i_ready !== 1'b0 || err_cfg !== 1'b1) begin n_fail++; $display("FAIL cfg_len17: got i_ready=%b err=%b want 0 1", i_ready, err_cfg); end
    err_clr = 1'b1; cfg_addr = 7'h10; cfg_rw = 1'b0; cfg_len = 5'd0; start = 1'b1;
    tick(1); err_clr = 1'b0; start = 1'b0;
    n_chk++; if (err_cfg !== 1'b1) begin n_fail++; $display("FAIL cfg_clr_vs_event: got %b want 1", err_cfg); end
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    n_chk++; if (err_cfg !== 1'b0 || tx_level !== 5'd2) begin n_fail++; $display("FAIL cfg_clr2: got err=%b level=%0d want 0 2", err_cfg, tx_level); end
  endtask

  task automatic test_boundaries;
    do_reset();
    for (int i = 0; i < 16; i++) host_push(8'(8'h10 + i));
    n_chk++; if (tx_full !== 1'b1 || tx_level !== 5'd16 || err_ovf !== 1'b0) begin n_fail++; $display("FAIL bnd_full: got full=%b level=%0d ovf=%b want 1 16 0", tx_full, tx_level, err_ovf); end
    host_push(8'hEE);
    n_chk++; if (err_ovf !== 1'b1 || tx_level !== 5'd16 || data_in !== 8'h10) begin n_fail++; $display("FAIL bnd_ovf: got ovf=%b level=%0d data_in=%h want 1 16 10", err_ovf, tx_level, data_in); end
    do_start(7'h2A, 1'b1, 5'd1);
    pulse_tx(6);
    n_chk++; if (busy !== 1'b1 || tx_level !== 5'd16) begin n_fail++; $display("FAIL bnd_rd_busy: got busy=%b tx_level=%0d want 1 16", busy, tx_level); end
    rx_byte = 8'hC3; rxff_wr = 1'b1;
    tick(2);
    rx_rd = 1'b1; tick(1); rx_rd = 1'b0;
    n_chk++; if (rx_level !== 5'd1 || rx_rdata !== 8'hC3 || err_udf !== 1'b1) begin n_fail++; $display("FAIL bnd_push_udf: got level=%0d rdata=%h udf=%b want 1 c3 1", rx_level, rx_rdata, err_udf); end
    tick(10); rxff_wr = 1'b0; tick(5);
    pulse_done();
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    n_chk++; if (err_ovf !== 1'b0 || err_udf !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bnd_clr: got ovf=%b udf=%b busy=%b want 0 0 0", err_ovf, err_udf, busy); end
  endtask

  task automatic test_nack;
    int d0;
    do_reset();
    host_push(8'h5A);
    host_push(8'h6B);
    do_start(7'h3F, 1'b0, 5'd2);
    n_chk++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL nack_req: got %b want 1", i_ready); end
    d0 = done_cnt;
    pulse_done();
    n_chk++; if (done_cnt - d0 !== 1 || busy !== 1'b0 || i_ready !== 1'b0) begin n_fail++; $display("FAIL nack_done: got dones=%0d busy=%b i_ready=%b want 1 0 0", done_cnt - d0, busy, i_ready); end
    n_chk++; if (tx_level !== 5'd2 || data_in !== 8'h5A) begin n_fail++; $display("FAIL nack_fifo: got level=%0d data_in=%h want 2 5a", tx_level, data_in); end
  endtask

  task automatic test_reset_mid;
    int d0;
    do_reset();
    host_push(8'h01); host_push(8'h02); host_push(8'h03);
    do_start(7'h33, 1'b0, 5'd3);
    pulse_tx(6);
    n_chk++; if (tx_level !== 5'd2 || data_in !== 8'h02 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_one_pop: got level=%0d data_in=%h busy=%b want 2 02 1", tx_level, data_in, busy); end
    #2 rst = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || tx_level !== 5'd0 || tx_empty !== 1'b1 || data_in !== 8'h00) begin n_fail++; $display("FAIL mid_async_rst: got busy=%b level=%0d empty=%b data_in=%h want 0 0 1 00", busy, tx_level, tx_empty, data_in); end
    tick(1); rst = 1'b1; tick(1);
    host_push(8'h99);
    do_start(7'h44, 1'b0, 5'd1);
    n_chk++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL mid_req: got %b want 1", i_ready); end
    #2 rst = 1'b0;
    #1;
    n_chk++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_drop: got %b want 0", i_ready); end
    tick(1); rst = 1'b1; tick(1);
    host_push(8'h99);
    do_start(7'h44, 1'b0, 5'd1);
    n_chk++; if (i_ready !== 1'b1 || addr !== 7'h44 || data_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_restart: got i_ready=%b addr=%h cnt=%0d want 1 44 0", i_ready, addr, data_cnt); end
    pulse_tx(6);
    d0 = done_cnt;
    pulse_done();
    n_chk++; if (tx_level !== 5'd0 || busy !== 1'b0 || done_cnt - d0 !== 1) begin n_fail++; $display("FAIL mid_complete: got level=%0d busy=%b dones=%0d want 0 0 1", tx_level, busy, done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_write3();
    test_read2();
    test_cfg_errors();
    test_boundaries();
    test_nack();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_host_fifo.md
# i2c_host_fifo

Host-side buffer and sequencer sitting directly upstream of the I2C master. It holds a TX byte FIFO feeding the master's `data_in` and an RX byte FIFO capturing its `data_out`. It converts host transfer requests into the master's `i_ready`/`addr`/`rw`/`data_cnt` and turns the master's level strobes into single FIFO pops and pushes. It also reports completion to the host.

## Interface
- `DEPTH`, default 16: entries per FIFO; must be a power of two and at least 16.
- `AW`, default 4: log2(DEPTH).
- `clk_en` in 1: block clock; the same source the master's divider runs from.
- `rst` in 1: reset, asynchronous, active-low.
- `tx_wr` in 1: host push of `tx_wdata` into the TX FIFO.
- `tx_wdata` in 8: host write byte.
- `rx_rd` in 1: host pop from the RX FIFO.
- `rx_rdata` out 8: RX FIFO head, show-ahead.
- `start` in 1: request a transfer using the `cfg_*` inputs.
- `cfg_addr` in 7: slave address.
- `cfg_rw` in 1: 0 = write, 1 = read.
- `cfg_len` in 5: byte count, 1..16.
- `busy` out 1: a transfer is in progress.
- `done_irq` out 1: one-cycle pulse at transfer end.
- `tx_level`, `rx_level` out AW+1: FIFO occupancy.
- `tx_full`, `tx_empty`, `rx_full`, `rx_empty` out 1: FIFO flags.
- `err_ovf`, `err_udf`, `err_cfg` out 1: sticky error flags.
- `err_clr` in 1: clears all three sticky flags.
- `i_ready` out 1: transfer request to the master.
- `addr` out 7, `rw` out 1, `data_cnt` out 4: master transfer config; `data_cnt` = len−1.
- `data_in` out 8: TX FIFO head, presented to the master.
- `txff_rd` in 1: master TX-load strobe (level).
- `rxff_wr` in 1: master RX-store strobe (level).
- `rx_byte` in 8: master `data_out`.
- `i2c_done` in 1: master completion strobe (level).

## Operation
- **Strobe handling.** `txff_rd`, `rxff_wr` and `i2c_done` each pass through a 2-flop synchronizer and an edge detector. Each strobe yields exactly one event per high pulse, whatever its width.
- **FSM states.** IDLE, REQ, BUSY, DONE.
- **IDLE.**
  - A `start` is rejected, with `err_cfg` set and the state held at IDLE, when any of these holds:
    - `cfg_len` is 0 or greater than 16;
    - `cfg_rw`=0 and `tx_level` < `cfg_len`;
    - `cfg_rw`=1 and DEPTH−`rx_level` < `cfg_len`.
  - Otherwise the block latches `addr`, `rw`, `data_cnt` and the length, clears the beat counter, and goes to REQ.
  - `start` while not in IDLE is ignored; no flag is set.
- **REQ.** `i_ready`=1. The first synchronized `txff_rd` rising edge (the master's address ACK phase) moves the FSM to BUSY. That edge is never a pop.
- **BUSY.**
  - Write: each `txff_rd` falling edge pops the TX FIFO while pops < len. Further strobes are ignored. The pop is on the falling edge so `data_in` stays stable for the whole strobe.
  - Read: `txff_rd` is ignored. Each `rxff_wr` rising edge pushes `rx_byte` while pushes < len.
  - A falling edge on `i2c_done` moves the FSM to DONE.
- **Address NACK.** On NACK the master goes straight to STOP. Zero beats are counted and the FIFOs are untouched.
- **DONE.** `done_irq`=1 for one cycle, then IDLE.
- **`busy`.** Equals 1 in REQ, BUSY and DONE.
- **Host port during a transfer.** Host pushes and pops stay legal. Simultaneous pushes and pops on the same FIFO both take effect and the level is unchanged.
- **FIFO boundaries.**
  - Push when full: dropped, `err_ovf` set.
  - Pop when empty: ignored, `rx_rdata`/`data_in` hold their value, `err_udf` set.
  - Pointers wrap modulo DEPTH.
  - Levels saturate logically at 0..DEPTH; full = (level == DEPTH).
- **Sticky errors.** `err_clr` clears the sticky flags. If an error event occurs in the same cycle as `err_clr`, the flag stays set.

## Timing
- **Reset values.** All outputs 0 except `tx_empty`=`rx_empty`=1. Both FIFOs are emptied and the FSM is in IDLE. Reset mid-transfer drops `i_ready` immediately, asynchronously, and discards any partial beat.
- **Host-side latency.**
  - `tx_wr` → `tx_level` increments next cycle; `data_in` is valid the next cycle when the FIFO was empty.
  - `rx_rd` → `rx_rdata` advances next cycle.
- **Master-side latency.** Strobe edge → FIFO pointer update is 3 `clk_en` cycles (2 sync + 1 edge register).
- **`start` handshake.** `start` accepted in IDLE → `i_ready`=1 and `busy`=1 next cycle.
- **`i_ready` hold.** `i_ready` stays high until the REQ→BUSY transition, a minimum of one master `sclk` period.
- **Completion.** `i2c_done` falling edge → `done_irq` 3 cycles later; `busy` falls 1 cycle after `done_irq`.

## Structure
- **Package `i2c_pkg`:** FSM state enum `host_st_t`, `I2C_MAX_LEN`=16, and `I2C_BYTE_W`=8. It is shared with the master.
- **Sub-module `sync_byte_fifo`:** parameterized DEPTH/AW show-ahead FIFO with push/pop/level/full/empty and ovf/udf pulses. It is instantiated twice. The synchronizers, edge detectors, FSM and beat counter stay in the top.

## Test plan
- **Write, 3 bytes.** Push 0xA5, 0x3C, 0x7E; `start` with addr 0x50, rw 0, len 3 → `i_ready` pulses, `data_cnt`=2, `data_in` shows A5, 3C, 7E in order. The 4th `txff_rd` strobe is ignored; `tx_level` ends at 0; one `done_irq`.
- **Read, 2 bytes.** `start` with rw 1, len 2; model drives `rx_byte` 0x11 then 0x22 with `rxff_wr` pulses of 40 cycles each → exactly 2 pushes; `rx_rdata`=0x11, then 0x22 after `rx_rd`.
- **Config errors.** `start` with len 0, and separately write len 4 with `tx_level`=2 → `err_cfg`=1, `i_ready` never asserts. `err_clr` → flag cleared.
- **Boundaries.** 17 host pushes → `tx_full` after 16, 17th dropped, `err_ovf`=1. In the same cycle, host `rx_rd` on an empty RX FIFO and a master push → push lands, `err_udf`=1.
- **Address NACK.** Master goes straight to STOP → `done_irq`, `tx_level` unchanged.
- **Reset mid-transfer.** Assert `rst` in BUSY after 1 of 3 pops → `i_ready`=0, FIFOs empty, IDLE. The next `start` works normally.
